// File: rtl/fp32_div_feeder.sv
// rtl/fp32_div_feeder.sv - credit-scheduled feeder and result re-aligner for the fixed-latency fp32_div IP
// Optional feature macro: FP32_DIV_ZERO_CLAMP_EN (zero-denominator quotients stored as +0.0)
module fp32_div_feeder #(
  parameter int DIV_LATENCY = 28,
  parameter int TAG_W       = 16,
  parameter int OBUF_DEPTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_num,
  input  logic [31:0]      in_den,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_valid,
  input  logic [31:0]      div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_quot,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             out_dz,
  output logic             busy
);

  localparam int AW = $clog2(OBUF_DEPTH);
  localparam int CW = AW + 1;

  logic accept;
  logic out_hs;

  // Credits: one per free output-buffer slot not already claimed by an in-flight op
  logic [CW-1:0] credits_q, credits_d;

  // Issue stage: operands to the divider plus the metadata travelling with them
  logic [31:0]      div_a_q, div_b_q;
  logic             div_valid_q;
  logic [TAG_W-1:0] iss_tag_q;
  logic             iss_last_q, iss_dz_q;

  // Alignment shift register: metadata delayed to line up with div_result
  logic [DIV_LATENCY-1:0] al_valid_q;
  logic [DIV_LATENCY-1:0] al_last_q;
  logic [DIV_LATENCY-1:0] al_dz_q;
  logic [TAG_W-1:0]       al_tag_q [DIV_LATENCY];

  // Output buffer storage and pointers (extra pointer bit distinguishes full from empty)
  logic [31:0]           fq_q [OBUF_DEPTH];
  logic [TAG_W-1:0]      ft_q [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] fl_q;
  logic [OBUF_DEPTH-1:0] fd_q;
  logic [AW:0]           wr_ptr_q, rd_ptr_q;

  logic        wr_en;
  logic [31:0] wr_quot;
  logic [AW:0] ptr_one;

  assign ptr_one  = {{AW{1'b0}}, 1'b1};
  assign in_ready = (credits_q != '0) && !rst;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign busy     = (credits_q != CW'(OBUF_DEPTH));

  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_valid = div_valid_q;

  assign wr_en = al_valid_q[DIV_LATENCY-1];
`ifdef FP32_DIV_ZERO_CLAMP_EN
  assign wr_quot = al_dz_q[DIV_LATENCY-1] ? 32'h0000_0000 : div_result;
`else
  assign wr_quot = div_result;
`endif

  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign out_quot  = fq_q[rd_ptr_q[AW-1:0]];
  assign out_tag   = ft_q[rd_ptr_q[AW-1:0]];
  assign out_last  = fl_q[rd_ptr_q[AW-1:0]];
  assign out_dz    = fd_q[rd_ptr_q[AW-1:0]];

  // Next credit count: accept consumes one, output handshake returns one
  always_comb begin
    credits_d = credits_q;
    if (accept && !out_hs) begin
      credits_d = credits_q - {{(CW-1){1'b0}}, 1'b1};
    end else if (!accept && out_hs) begin
      credits_d = credits_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Credit register
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CW'(OBUF_DEPTH);
    end else begin
      credits_q <= credits_d;
    end
  end

  // Issue stage: one-cycle div_valid pulse per accept; operands hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_valid_q <= 1'b0;
      iss_tag_q   <= '0;
      iss_last_q  <= 1'b0;
      iss_dz_q    <= 1'b0;
    end else begin
      div_valid_q <= accept;
      if (accept) begin
        div_a_q    <= in_num;
        div_b_q    <= in_den;
        iss_tag_q  <= in_tag;
        iss_last_q <= in_last;
        iss_dz_q   <= (in_den[30:0] == 31'd0);
      end
    end
  end

  // Alignment shift: advances every cycle so the tail meets div_result exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      al_valid_q <= '0;
      al_last_q  <= '0;
      al_dz_q    <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        al_tag_q[i] <= '0;
      end
    end else begin
      al_valid_q[0] <= div_valid_q;
      al_last_q[0]  <= iss_last_q;
      al_dz_q[0]    <= iss_dz_q;
      al_tag_q[0]   <= iss_tag_q;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        al_valid_q[i] <= al_valid_q[i-1];
        al_last_q[i]  <= al_last_q[i-1];
        al_dz_q[i]    <= al_dz_q[i-1];
        al_tag_q[i]   <= al_tag_q[i-1];
      end
    end
  end

  // Output buffer: write aligned results, pop on handshake; credits rule out overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fl_q     <= '0;
      fd_q     <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        fq_q[i] <= '0;
        ft_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        fq_q[wr_ptr_q[AW-1:0]] <= wr_quot;
        ft_q[wr_ptr_q[AW-1:0]] <= al_tag_q[DIV_LATENCY-1];
        fl_q[wr_ptr_q[AW-1:0]] <= al_last_q[DIV_LATENCY-1];
        fd_q[wr_ptr_q[AW-1:0]] <= al_dz_q[DIV_LATENCY-1];
        wr_ptr_q <= wr_ptr_q + ptr_one;
      end
      if (out_hs) begin
        rd_ptr_q <= rd_ptr_q + ptr_one;
      end
    end
  end

endmodule

// File: tb/tb_fp32_div_feeder.sv
// tb/tb_fp32_div_feeder.sv - directed self-checking bench for fp32_div_feeder
module tb_fp32_div_feeder;

  localparam int DIV_LATENCY = 28;
  localparam int TAG_W       = 16;
  localparam int OBUF_DEPTH  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_num;
  logic [31:0]      in_den;
  logic [TAG_W-1:0] in_tag;
  logic             in_last;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_valid;
  logic [31:0]      div_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_quot;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;
  logic             out_dz;
  logic             busy;

  fp32_div_feeder #(
    .DIV_LATENCY(DIV_LATENCY),
    .TAG_W(TAG_W),
    .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
    .in_tag(in_tag), .in_last(in_last),
    .div_a(div_a), .div_b(div_b), .div_valid(div_valid), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_quot(out_quot),
    .out_tag(out_tag), .out_last(out_last), .out_dz(out_dz), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference quotients for the directed vectors; other operands get a recognisable mix
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h80000000) return 32'hFF800000;
    if (a == 32'h40000000 && b == 32'h00000000) return 32'h7F800000;
    return a ^ b;
  endfunction

  function automatic logic [31:0] exp_quot(input logic [31:0] a, input logic [31:0] b);
`ifdef FP32_DIV_ZERO_CLAMP_EN
    if (b[30:0] == 31'd0) return 32'h0;
`endif
    return ref_div(a, b);
  endfunction

  // Behavioural divider: fixed latency, no reset, never stalls
  logic [31:0] dpipe [DIV_LATENCY];
  always @(posedge clk) begin
    dpipe[0] <= div_valid ? ref_div(div_a, div_b) : 32'hDEADBEEF;
    for (int i = 1; i < DIV_LATENCY; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_result = dpipe[DIV_LATENCY-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]      q;
    logic [TAG_W-1:0] tag;
    logic             last;
    logic             dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_acc = 0, n_out = 0, n_div = 0, n_ov = 0, n_stall = 0;
  int   last_out_cyc = 0, first_out_cyc = 0;
  bit   arm_first = 0;

  // Scoreboard and event counters, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (div_valid) n_div++;
      if (out_valid) n_ov++;
      if (in_valid && !in_ready) n_stall++;
      if (in_valid && in_ready) begin
        e.q = exp_quot(in_num, in_den);
        e.tag = in_tag;
        e.last = in_last;
        e.dz = (in_den[30:0] == 31'd0);
        sb_q.push_back(e);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_quot", out_quot, e.q);
          chk("sb_tag", out_tag, e.tag);
          chk("sb_last", out_last, e.last);
          chk("sb_dz", out_dz, e.dz);
        end
        n_out++;
        last_out_cyc = cyc;
        if (arm_first) begin
          first_out_cyc = cyc;
          arm_first = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] num, input logic [31:0] den,
                      input logic [TAG_W-1:0] tag, input logic last);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_num = num;
    in_den = den;
    in_tag = tag;
    in_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) break;
    end
    chk("send_accepted", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", busy, 0);
    tick();
    chk("drain_sb_empty", sb_q.size(), 0);
  endtask

  int a0, acc0, div0, out0, ov0;
  logic seen;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_num = '0;
    in_den = '0;
    in_tag = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_quot", out_quot, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_div_a", div_a, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // Single op: 6.0 / 2.0, out_valid 29 edges after the accept edge
    out_ready = 1'b1;
    send(32'h40C00000, 32'h40000000, 16'd5, 1'b0);
    a0 = cyc;
    in_valid = 1'b0;
    #1;
    chk("issue_div_valid", div_valid, 1);
    chk("issue_div_a", div_a, 32'h40C00000);
    chk("issue_div_b", div_b, 32'h40000000);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("single_seen", seen, 1);
    chk("single_latency", cyc - a0, DIV_LATENCY + 1);
    chk("single_quot", out_quot, 32'h40400000);
    chk("single_tag", out_tag, 5);
    chk("single_dz", out_dz, 0);
    tick();
    chk("single_busy_after", busy, 0);
    chk("single_ov_after", out_valid, 0);

    // Streaming: 100 back-to-back, last only on tag 99
    n_stall = 0;
    out0 = n_out;
    arm_first = 1;
    for (int t = 0; t < 100; t++) send(32'h42000000 + t, 32'h3F000000 + (t << 4), 16'(t), t == 99);
    in_valid = 1'b0;
    drain();
    chk("stream_count", n_out - out0, 100);
    chk("stream_one_per_cycle", last_out_cyc - first_out_cyc, 99);
    chk("stream_no_stall", n_stall, 0);

    // Backpressure: exactly OBUF_DEPTH accepts, then nothing issues
    out_ready = 1'b0;
    acc0 = n_acc;
    div0 = n_div;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_tag = 16'(300 + n_acc - acc0);
      in_num = 32'h3F800000 + (n_acc - acc0);
      in_den = 32'h40000000;
      tick();
    end
    chk("bp_accepts", n_acc - acc0, OBUF_DEPTH);
    chk("bp_in_ready", in_ready, 0);
    repeat (40) tick();
    chk("bp_no_div_valid", n_div - div0, OBUF_DEPTH);
    out_ready = 1'b1;
    #2;
    chk("bp_pulse_valid", out_valid, 1);
    chk("bp_pulse_tag", out_tag, 300);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("bp_one_more_accept", n_acc - acc0, OBUF_DEPTH + 1);
    chk("bp_full_again", in_ready, 0);

    // Simultaneous accept and output with zero credits
    acc0 = n_acc;
    out0 = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_tag = 16'(400 + n_acc - acc0);
      in_num = 32'h40800000 + (n_acc - acc0);
      in_den = 32'h3FC00000;
      tick();
    end
    in_valid = 1'b0;
    chk("sim_accepts", n_acc - acc0, 49);
    chk("sim_outputs", n_out - out0, 50);
    drain();

    // Zero denominators: -0.0 and +0.0 flag dz, a denormal does not
    send(32'h3F800000, 32'h80000000, 16'h77, 1'b0);
    send(32'h40000000, 32'h00000000, 16'h78, 1'b0);
    send(32'h3F800000, 32'h80000001, 16'h79, 1'b1);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("dz_seen", seen, 1);
    chk("dz_flag", out_dz, 1);
`ifdef FP32_DIV_ZERO_CLAMP_EN
    chk("dz_quot", out_quot, 32'h00000000);
`else
    chk("dz_quot", out_quot, 32'hFF800000);
`endif
    drain();

    // Reset mid-flight: in-flight work vanishes, then normal service resumes
    for (int i = 0; i < 10; i++) send(32'h41000000 + i, 32'h40400000, 16'(500 + i), 1'b0);
    in_valid = 1'b0;
    repeat (5) tick();
    ov0 = n_ov;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (60) tick();
    chk("rst_mid_no_out", n_ov - ov0, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    out0 = n_out;
    send(32'h40C00000, 32'h40000000, 16'd600, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("rst_mid_new_op", n_out - out0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
